// File: rtl/pantalla_dma_wb.sv
// Wishbone LCD window-write controller for 8080-style parallel TFT panels.
// Optional interrupt output enabled by defining PANTALLA_DMA_IRQ_EN.
module pantalla_dma_wb #(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int WR_CYCLES  = 2,
    parameter int COORD_W    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic          wb_ack_o,
    input  logic          wb_we_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [31:0]   wb_dat_i,
    output logic [31:0]   wb_dat_o,
    output logic [DW-1:0] lcd_d,
    output logic          lcd_dc,
    output logic          lcd_wr_n,
    output logic          lcd_cs_n,
    output logic          lcd_rst_n,
    output logic          irq_o
);
    // state  | meaning
    // IDLE   | waiting for START; drains FIFO entries as raw writes
    // RAW    | single raw FIFO write in flight
    // CHECK  | validate latched window, load pixel count
    // CASET  | column address command + 4 x bytes
    // RASET  | row address command + 4 y bytes
    // RAMWR  | memory write command
    // PIX    | pixel stream (solid colour or FIFO)
    // DONE   | wait for last strobe, flag completion
    typedef enum logic [2:0] {
        S_IDLE, S_RAW, S_CHECK, S_CASET, S_RASET, S_RAMWR, S_PIX, S_DONE
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam int CW = 2 * COORD_W;
    localparam logic [TW-1:0] T_LOAD = TW'(WR_CYCLES - 1);

    state_t state, state_nx;

    logic               wb_req, wb_wr;
    logic [2:0]         reg_adr;
    logic [31:0]        rdata, w1c;
    logic               start_req, ctrl_src, ctrl_ie, prst;
    logic [COORD_W-1:0] x0, x1, y0, y1;
    logic [15:0]        color;
    logic               st_done, st_ovf, st_err;

    logic [COORD_W-1:0] cur_x0, cur_x1, cur_y0, cur_y1;
    logic [15:0]        cur_color;
    logic               cur_src;
    logic [CW-1:0]      pix_cnt, win_w, win_h;
    logic [2:0]         byte_idx;
    logic               pix_lo;

    logic [DW:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [LW-1:0]      level;
    logic               fifo_full, fifo_empty, push, push_ok, pop;
    logic [DW:0]        fifo_q;

    logic               bw_busy, bw_low, bw_ready;
    logic [TW-1:0]      bw_tmr;

    logic               issue, issue_dc, latch_cfg, cnt_load, cnt_dec, lo_tgl;
    logic               idx_clr, idx_inc, set_err, set_done;
    logic [DW-1:0]      issue_data, color_word;
    logic [COORD_W-1:0] coord;
    logic [15:0]        w16;
    logic [7:0]         win_byte;

    logic               unused_bits;
    assign unused_bits = ^{wb_adr_i, wb_dat_i, wb_sel_i};

    assign wb_req  = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wb_wr   = wb_req & wb_we_i & (wb_sel_i != 4'b0);
    assign reg_adr = wb_adr_i[4:2];
    assign w1c     = (wb_wr && reg_adr == 3'd7) ? wb_dat_i : 32'h0;

    always_comb begin
        rdata = '0;
        case (reg_adr)
            3'd0: rdata[2:0] = {ctrl_ie, ctrl_src, state != S_IDLE};
            3'd1: rdata[0] = prst;
            3'd2: begin
                rdata[COORD_W-1:0]     = x0;
                rdata[16+COORD_W-1:16] = x1;
            end
            3'd3: begin
                rdata[COORD_W-1:0]     = y0;
                rdata[16+COORD_W-1:16] = y1;
            end
            3'd4: rdata[15:0] = color;
            3'd7: rdata[12:0] = {st_err, st_ovf, st_done, fifo_empty, fifo_full, 8'(level)};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            start_req <= 1'b0;
            ctrl_src  <= 1'b0;
            prst      <= 1'b0;
            x0 <= '0; x1 <= '0; y0 <= '0; y1 <= '0;
            color     <= '0;
            st_done   <= 1'b0;
            st_ovf    <= 1'b0;
            st_err    <= 1'b0;
        end else begin
            wb_ack_o  <= wb_req;
            wb_dat_o  <= (wb_req && !wb_we_i) ? rdata : 32'h0;
            start_req <= 1'b0;
            if (wb_wr) begin
                case (reg_adr)
                    3'd0: begin
                        start_req <= wb_dat_i[0];
                        ctrl_src  <= wb_dat_i[1];
                    end
                    3'd1: prst <= wb_dat_i[0];
                    3'd2: begin
                        x0 <= wb_dat_i[COORD_W-1:0];
                        x1 <= wb_dat_i[16+COORD_W-1:16];
                    end
                    3'd3: begin
                        y0 <= wb_dat_i[COORD_W-1:0];
                        y1 <= wb_dat_i[16+COORD_W-1:16];
                    end
                    3'd4: color <= wb_dat_i[15:0];
                    default: ;
                endcase
            end
            // a new event wins over a simultaneous clear
            st_done <= set_done | (st_done & ~w1c[10]);
            st_ovf  <= (push & fifo_full & ~pop) | (st_ovf & ~w1c[11]);
            st_err  <= set_err | (st_err & ~w1c[12]);
        end
    end

`ifdef PANTALLA_DMA_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_ie <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            if (wb_wr && reg_adr == 3'd0)
                ctrl_ie <= wb_dat_i[2];
            irq_o <= ctrl_ie & (st_done | st_ovf | st_err);
        end
    end
`else
    assign ctrl_ie = 1'b0;
    assign irq_o   = 1'b0;
`endif

    assign lcd_rst_n = ~prst;
    assign lcd_cs_n  = (state == S_IDLE);

    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign fifo_q     = fifo_mem[rd_ptr];
    assign push       = wb_wr && (reg_adr == 3'd5 || reg_adr == 3'd6);
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= {reg_adr == 3'd6, wb_dat_i[DW-1:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                level <= level + LW'(1);
            else if (!push_ok && pop)
                level <= level - LW'(1);
        end
    end

    // ready during the final high-phase clock so strobes run back to back
    assign bw_ready = !bw_busy || (!bw_low && bw_tmr == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lcd_d    <= '0;
            lcd_dc   <= 1'b0;
            lcd_wr_n <= 1'b1;
            bw_busy  <= 1'b0;
            bw_low   <= 1'b0;
            bw_tmr   <= '0;
        end else if (issue) begin
            lcd_d    <= issue_data;
            lcd_dc   <= issue_dc;
            lcd_wr_n <= 1'b0;
            bw_busy  <= 1'b1;
            bw_low   <= 1'b1;
            bw_tmr   <= T_LOAD;
        end else if (bw_busy) begin
            if (bw_tmr != '0) begin
                bw_tmr <= bw_tmr - TW'(1);
            end else if (bw_low) begin
                lcd_wr_n <= 1'b1;
                bw_low   <= 1'b0;
                bw_tmr   <= T_LOAD;
            end else begin
                bw_busy <= 1'b0;
            end
        end
    end

    assign win_w = CW'(cur_x1) - CW'(cur_x0) + CW'(1);
    assign win_h = CW'(cur_y1) - CW'(cur_y0) + CW'(1);

    always_comb begin
        coord      = '0;
        w16        = '0;
        win_byte   = '0;
        color_word = '0;
        if (state == S_CASET)
            coord = (byte_idx < 3'd3) ? cur_x0 : cur_x1;
        else
            coord = (byte_idx < 3'd3) ? cur_y0 : cur_y1;
        w16 = 16'(coord);
        if (byte_idx == 3'd0)
            win_byte = (state == S_CASET) ? 8'h2A : 8'h2B;
        else if (byte_idx[0])
            win_byte = w16[15:8];
        else
            win_byte = w16[7:0];
        if (DW == 8)
            color_word = DW'(pix_lo ? cur_color[7:0] : cur_color[15:8]);
        else
            color_word = DW'(cur_color);
    end

    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        issue_data = '0;
        issue_dc   = 1'b0;
        pop        = 1'b0;
        latch_cfg  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        lo_tgl     = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        set_err    = 1'b0;
        set_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_req) begin
                    latch_cfg = 1'b1;
                    state_nx  = S_CHECK;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    issue      = 1'b1;
                    issue_data = fifo_q[DW-1:0];
                    issue_dc   = fifo_q[DW];
                    state_nx   = S_RAW;
                end
            end
            S_RAW: if (bw_ready) state_nx = S_IDLE;
            S_CHECK: begin
                if (cur_x1 < cur_x0 || cur_y1 < cur_y0) begin
                    set_err  = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    cnt_load = 1'b1;
                    idx_clr  = 1'b1;
                    state_nx = S_CASET;
                end
            end
            S_CASET, S_RASET: begin
                if (bw_ready) begin
                    issue      = 1'b1;
                    issue_data = DW'(win_byte);
                    issue_dc   = (byte_idx != 3'd0);
                    if (byte_idx == 3'd4) begin
                        idx_clr  = 1'b1;
                        state_nx = (state == S_CASET) ? S_RASET : S_RAMWR;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            S_RAMWR: begin
                if (bw_ready) begin
                    issue      = 1'b1;
                    issue_data = DW'(8'h2C);
                    state_nx   = S_PIX;
                end
            end
            S_PIX: begin
                if (bw_ready && (!cur_src || !fifo_empty)) begin
                    issue    = 1'b1;
                    issue_dc = 1'b1;
                    if (cur_src) begin
                        pop        = 1'b1;
                        issue_data = fifo_q[DW-1:0];
                    end else begin
                        issue_data = color_word;
                    end
                    lo_tgl = (DW == 8);
                    if (DW != 8 || pix_lo) begin
                        cnt_dec = 1'b1;
                        if (pix_cnt == CW'(1))
                            state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bw_ready) begin
                    set_done = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cur_x0 <= '0; cur_x1 <= '0; cur_y0 <= '0; cur_y1 <= '0;
            cur_color <= '0;
            cur_src   <= 1'b0;
            pix_cnt   <= '0;
            byte_idx  <= '0;
            pix_lo    <= 1'b0;
        end else begin
            state <= state_nx;
            if (latch_cfg) begin
                cur_x0    <= x0;
                cur_x1    <= x1;
                cur_y0    <= y0;
                cur_y1    <= y1;
                cur_color <= color;
                cur_src   <= ctrl_src;
            end
            if (cnt_load) begin
                pix_cnt <= win_w * win_h;
                pix_lo  <= 1'b0;
            end else begin
                if (cnt_dec) pix_cnt <= pix_cnt - CW'(1);
                if (lo_tgl)  pix_lo  <= ~pix_lo;
            end
            if (idx_clr)
                byte_idx <= '0;
            else if (idx_inc)
                byte_idx <= byte_idx + 3'd1;
        end
    end
endmodule

// File: tb/tb_pantalla_dma_wb.sv
// Directed bench for pantalla_dma_wb: register table plus fill, stream, overflow,
// error and reset-abort sequences with a strobe monitor capturing every panel write.
module tb_pantalla_dma_wb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_stb = 1'b0, wb_cyc = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat_w = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_ack;
    logic [31:0] wb_dat_r;
    logic [15:0] lcd_d;
    logic        lcd_dc, lcd_wr_n, lcd_cs_n, lcd_rst_n, irq;

    always #5 clk = ~clk;

    pantalla_dma_wb dut (
        .clk(clk), .rst(rst),
        .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_ack_o(wb_ack), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_sel_i(wb_sel), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
        .lcd_d(lcd_d), .lcd_dc(lcd_dc), .lcd_wr_n(lcd_wr_n), .lcd_cs_n(lcd_cs_n),
        .lcd_rst_n(lcd_rst_n), .irq_o(irq)
    );

    int n_cmp = 0;
    int n_err = 0;

    // strobe monitor: one captured {dc,d} per rising edge of lcd_wr_n
    int          cyc = 0;
    int          low_cnt = 0;
    int          bad_cnt = 0;
    logic        prev_wr = 1'b1;
    logic [16:0] held = '0;
    logic [16:0] cap [$];
    int          fall_cy [$];
    int          rise_cy [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst && !lcd_wr_n) begin
            low_cnt++;
            if (lcd_cs_n) bad_cnt++;
            if (prev_wr) begin
                fall_cy.push_back(cyc);
                held = {lcd_dc, lcd_d};
            end else if ({lcd_dc, lcd_d} != held) begin
                bad_cnt++;
            end
        end
        if (rst && lcd_wr_n && !prev_wr) begin
            cap.push_back({lcd_dc, lcd_d});
            rise_cy.push_back(cyc);
            if ({lcd_dc, lcd_d} != held) bad_cnt++;
        end
        prev_wr = lcd_wr_n;
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs [$];

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                input logic [31:0] dat, input logic [31:0] exp, input string name);
        vec_t v;
        v.we = we; v.adr = adr; v.sel = sel; v.dat = dat; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int n = 0;
        wb_adr = adr; wb_dat_w = dat; wb_sel = sel; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 8);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        if (!wb_ack) check("write_ack_timeout", 32'h0, 32'h1);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        int n = 0;
        wb_adr = adr; wb_sel = 4'hF; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 8);
        dat = wb_dat_r;
        wb_stb = 1'b0; wb_cyc = 1'b0;
        if (!wb_ack) check("read_ack_timeout", 32'h0, 32'h1);
    endtask

    task automatic read_check(input string nm, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_read(adr, r);
        check(nm, r, exp);
    endtask

    task automatic wait_caps(input int n, input int budget, input string nm);
        int k = 0;
        while (cap.size() < n && k < budget) begin @(posedge clk); #1; k++; end
        if (cap.size() < n) check(nm, cap.size(), n);
    endtask

    task automatic wait_idle(input string nm);
        logic [31:0] r;
        int n = 0;
        do begin wb_read(32'h0, r); n++; end while (r[0] && n < 1500);
        check(nm, {31'b0, r[0]}, 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lbase, fbase;
        logic [31:0] ctrl_rb;

`ifdef PANTALLA_DMA_IRQ_EN
        ctrl_rb = 32'h6;
`else
        ctrl_rb = 32'h2;
`endif
        vecs.push_back(mk(1, 32'h04, 4'hF, 32'h1,        0,            "prst_w"));
        vecs.push_back(mk(0, 32'h04, 4'hF, 0,            32'h1,        "prst_r1"));
        vecs.push_back(mk(1, 32'h04, 4'hF, 32'h0,        0,            "prst_w0"));
        vecs.push_back(mk(0, 32'h04, 4'hF, 0,            32'h0,        "prst_r0"));
        vecs.push_back(mk(1, 32'h08, 4'hF, 32'hFFFFFFFF, 0,            "xwin_w"));
        vecs.push_back(mk(0, 32'h08, 4'hF, 0,            32'h01FF01FF, "xwin_mask"));
        vecs.push_back(mk(1, 32'h0C, 4'hF, 32'h00030002, 0,            "ywin_w"));
        vecs.push_back(mk(0, 32'h0C, 4'hF, 0,            32'h00030002, "ywin_r"));
        vecs.push_back(mk(1, 32'h10, 4'hF, 32'h1234ABCD, 0,            "color_w"));
        vecs.push_back(mk(0, 32'h10, 4'hF, 0,            32'h0000ABCD, "color_r"));
        vecs.push_back(mk(1, 32'h10, 4'h0, 32'h00005555, 0,            "color_sel0"));
        vecs.push_back(mk(0, 32'h10, 4'hF, 0,            32'h0000ABCD, "color_sel0_kept"));
        vecs.push_back(mk(1, 32'h00, 4'hF, 32'h6,        0,            "ctrl_w"));
        vecs.push_back(mk(0, 32'h00, 4'hF, 0,            ctrl_rb,      "ctrl_r"));
        vecs.push_back(mk(1, 32'h00, 4'hF, 32'h0,        0,            "ctrl_w0"));
        vecs.push_back(mk(0, 32'h14, 4'hF, 0,            32'h0,        "cmd_r"));
        vecs.push_back(mk(0, 32'h1C, 4'hF, 0,            32'h200,      "status_r"));

        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, wb_ack}, 0);
        check("rst_dat_o", wb_dat_r, 0);
        check("rst_lcd_d", {16'b0, lcd_d}, 0);
        check("rst_dc", {31'b0, lcd_dc}, 0);
        check("rst_wr_n", {31'b0, lcd_wr_n}, 1);
        check("rst_cs_n", {31'b0, lcd_cs_n}, 1);
        check("rst_lcd_rst_n", {31'b0, lcd_rst_n}, 1);
        check("rst_irq", {31'b0, irq}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        read_check("rst_status", 32'h1C, 32'h200);

        // single-cycle ack and panel reset pin
        wb_write(32'h04, 32'h1, 4'hF);
        @(posedge clk); #1;
        check("ack_one_cycle", {31'b0, wb_ack}, 0);
        check("prst_pin", {31'b0, lcd_rst_n}, 0);

        foreach (vecs[i]) begin
            if (vecs[i].we)
                wb_write(vecs[i].adr, vecs[i].dat, vecs[i].sel);
            else
                read_check(vecs[i].name, vecs[i].adr, vecs[i].exp);
        end
        check("prst_release", {31'b0, lcd_rst_n}, 1);

        // solid fill 2x2
        begin
            logic [16:0] exp_seq [15];
            exp_seq = '{17'h0002A, 17'h10000, 17'h10000, 17'h10000, 17'h10001,
                        17'h0002B, 17'h10000, 17'h10000, 17'h10000, 17'h10001,
                        17'h0002C, 17'h1F800, 17'h1F800, 17'h1F800, 17'h1F800};
            wb_write(32'h08, 32'h00010000, 4'hF);
            wb_write(32'h0C, 32'h00010000, 4'hF);
            wb_write(32'h10, 32'h0000F800, 4'hF);
            base = cap.size(); lbase = low_cnt; fbase = fall_cy.size();
            wb_write(32'h00, 32'h1, 4'hF);
            wait_idle("fill_busy_clear");
            check("fill_writes", cap.size() - base, 15);
            if (cap.size() >= base + 15) begin
                for (int i = 0; i < 15; i++)
                    check($sformatf("fill_word%0d", i), {15'b0, cap[base+i]}, {15'b0, exp_seq[i]});
                check("fill_clocks", rise_cy[base+14] - fall_cy[fbase] + 2, 60);
            end
            check("fill_low_clocks", low_cnt - lbase, 30);
            read_check("fill_status_done", 32'h1C, 32'h600);
            read_check("fill_ctrl_idle", 32'h00, 32'h0);
            wb_write(32'h1C, 32'h400, 4'hF);
            read_check("done_w1c", 32'h1C, 32'h200);
        end

        // FIFO stream, stalled on empty FIFO
        wb_write(32'h08, 32'h00030003, 4'hF);
        wb_write(32'h0C, 32'h00050005, 4'hF);
        base = cap.size();
        wb_write(32'h00, 32'h3, 4'hF);
        wait_caps(base + 11, 300, "stream_header_timeout");
        repeat (20) @(posedge clk);
        #1;
        check("stall_writes", cap.size() - base, 11);
        check("stall_wr_n", {31'b0, lcd_wr_n}, 1);
        check("stall_cs_n", {31'b0, lcd_cs_n}, 0);
        read_check("stall_ctrl_busy", 32'h00, 32'h3);
        wb_write(32'h18, 32'h000007E0, 4'hF);
        wait_caps(base + 12, 100, "stream_pixel_timeout");
        wait_idle("stream_busy_clear");
        check("stream_writes", cap.size() - base, 12);
        if (cap.size() >= base + 12) begin
            check("stream_x_lo", {15'b0, cap[base+4]}, 32'h10003);
            check("stream_y_lo", {15'b0, cap[base+9]}, 32'h10005);
            check("stream_pixel", {15'b0, cap[base+11]}, 32'h107E0);
        end
        read_check("stream_status", 32'h1C, 32'h600);
        wb_write(32'h1C, 32'h400, 4'hF);

        // overflow during a 16x16 fill, then raw drain
        wb_write(32'h08, 32'h000F0000, 4'hF);
        wb_write(32'h0C, 32'h000F0000, 4'hF);
        wb_write(32'h10, 32'h0000001F, 4'hF);
        base = cap.size();
        wb_write(32'h00, 32'h1, 4'hF);
        for (int i = 0; i <= 16; i++)
            wb_write(32'h14, 32'h10 + i, 4'hF);
        read_check("ovf_status", 32'h1C, 32'h910);
        wait_caps(base + 283, 4000, "drain_timeout");
        repeat (10) @(posedge clk);
        #1;
        check("drain_total", cap.size() - base, 283);
        if (cap.size() >= base + 283) begin
            check("ovf_first_pixel", {15'b0, cap[base+11]}, 32'h1001F);
            for (int i = 0; i < 16; i++)
                check($sformatf("drain%0d", i), {15'b0, cap[base+267+i]}, 32'h10 + i);
        end
        read_check("drain_status", 32'h1C, 32'hE00);
        wb_write(32'h1C, 32'h1C00, 4'hF);
        read_check("drain_w1c", 32'h1C, 32'h200);
        check("monitor_stable_cs", bad_cnt, 0);

        // inverted window: error, no strobes
        wb_write(32'h08, 32'h00000005, 4'hF);
        wb_write(32'h0C, 32'h00000000, 4'hF);
        fbase = fall_cy.size();
        wb_write(32'h00, 32'h5, 4'hF);
        repeat (20) @(posedge clk);
        #1;
        check("err_no_strobe", fall_cy.size() - fbase, 0);
        read_check("err_status", 32'h1C, 32'h1200);
`ifdef PANTALLA_DMA_IRQ_EN
        check("irq_set", {31'b0, irq}, 1);
        wb_write(32'h1C, 32'h1000, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        check("irq_clear", {31'b0, irq}, 0);
`else
        check("irq_tied_low", {31'b0, irq}, 0);
        wb_write(32'h1C, 32'h1000, 4'hF);
`endif
        read_check("err_w1c", 32'h1C, 32'h200);

        // reset in the middle of a transfer
        wb_write(32'h08, 32'h000F0000, 4'hF);
        wb_write(32'h0C, 32'h000F0000, 4'hF);
        wb_write(32'h00, 32'h1, 4'hF);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_wr_n", {31'b0, lcd_wr_n}, 1);
        check("abort_cs_n", {31'b0, lcd_cs_n}, 1);
        check("abort_lcd_d", {16'b0, lcd_d}, 0);
        check("abort_dc", {31'b0, lcd_dc}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        read_check("abort_status", 32'h1C, 32'h200);
        read_check("abort_xwin", 32'h08, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
